// File: rtl/md_scheduler.sv
// rtl/md_scheduler.sv - HI/LO mul/div sequencer: issue accept, latency countdown, HI/LO write strobe, ID stall (option: MD_DIV0_FAST_EN)
module md_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       MDStartE,
  input  logic [1:0] MDOpE,
  input  logic       FlushE,
  input  logic       HiLoUseD,
  input  logic       DivZeroE,
  output logic       MDGo,
  output logic [1:0] MDOp,
  output logic       MDBusy,
  output logic       HiLoWrite,
  output logic       Stall_MD
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic [CNT_W-1:0] load_cnt;
  logic             fast_done;

  // New work is taken when nothing is in flight or when the previous op is retiring this cycle.
  assign accept = MDStartE & ~FlushE & ((state == IDLE) | (state == DONE));
  assign MDGo   = accept;

  // The first cycle after issue is already counted, so the countdown starts at N-2.
  assign load_cnt = MDOpE[1] ? CNT_W'(DIV_CYCLES - 2) : CNT_W'(MULT_CYCLES - 2);

`ifdef MD_DIV0_FAST_EN
  assign fast_done = MDOpE[1] & DivZeroE;
`else
  logic unused_div_zero;
  assign unused_div_zero = DivZeroE;
  assign fast_done       = 1'b0;
`endif

  // Both outputs decode directly from the state register, so they carry no combinational input path.
  assign MDBusy    = (state == BUSY);
  assign HiLoWrite = (state == DONE);

  // DONE does not stall: HI/LO lands this cycle and the following ID read sees it via write-first.
  assign Stall_MD = HiLoUseD & (accept | (state == BUSY));

  // Operation FSM: capture op on accept, count down the latency, retire through DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      MDOp  <= 2'b00;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            MDOp <= MDOpE;
            if (fast_done) begin
              state <= DONE;
              cnt   <= '0;
            end else begin
              state <= BUSY;
              cnt   <= load_cnt;
            end
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= DONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_scheduler.sv
// tb/tb_md_scheduler.sv - directed scoreboard bench for md_scheduler
module tb_md_scheduler;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
`ifdef MD_DIV0_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       MDStartE;
  logic [1:0] MDOpE;
  logic       FlushE;
  logic       HiLoUseD;
  logic       DivZeroE;
  logic       MDGo;
  logic [1:0] MDOp;
  logic       MDBusy;
  logic       HiLoWrite;
  logic       Stall_MD;

  int         cyc;
  int         checks;
  int         failures;
  int         sb[$];
  logic [1:0] op_model;

  md_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .MDStartE  (MDStartE),
    .MDOpE     (MDOpE),
    .FlushE    (FlushE),
    .HiLoUseD  (HiLoUseD),
    .DivZeroE  (DivZeroE),
    .MDGo      (MDGo),
    .MDOp      (MDOp),
    .MDBusy    (MDBusy),
    .HiLoWrite (HiLoWrite),
    .Stall_MD  (Stall_MD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One pipeline cycle: drive inputs, check outputs mid-cycle, advance the model across the edge.
  task automatic step(input logic s, input logic [1:0] op, input logic fl, input logic use_d,
                      input logic dz, input logic eg, input logic eb, input logic es);
    logic ehw;
    MDStartE = s;
    MDOpE    = op;
    FlushE   = fl;
    HiLoUseD = use_d;
    DivZeroE = dz;
    #3;
    ehw = 1'b0;
    if (sb.size() > 0 && sb[0] == cyc) begin
      ehw = 1'b1;
      void'(sb.pop_front());
    end
    chk("MDGo", {1'b0, MDGo}, {1'b0, eg});
    chk("MDBusy", {1'b0, MDBusy}, {1'b0, eb});
    chk("Stall_MD", {1'b0, Stall_MD}, {1'b0, es});
    chk("HiLoWrite", {1'b0, HiLoWrite}, {1'b0, ehw});
    chk("MDOp", MDOp, op_model);
    if (eg) begin
      if (op[1] && dz && FAST) sb.push_back(cyc + 1);
      else if (op[1])          sb.push_back(cyc + DIV_N);
      else                     sb.push_back(cyc + MULT_N);
    end
    @(posedge clk);
    cyc++;
    if (reset) begin
      sb.delete();
      op_model = 2'b00;
    end else if (eg) begin
      op_model = op;
    end
    #1;
  endtask

  initial begin
    cyc = 0; checks = 0; failures = 0; op_model = 2'b00;
    reset = 1'b1; MDStartE = 1'b0; MDOpE = 2'b00; FlushE = 1'b0; HiLoUseD = 1'b0; DivZeroE = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    // reset state while reset is held
    step(0, 2'b00, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    step(0, 2'b00, 0, 0, 0, 0, 0, 0);

    // mult: MDGo@0, busy 1..4, HiLoWrite@5, idle@6
    step(1, 2'b00, 0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) step(0, 2'b00, 0, 0, 0, 0, 1, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0);

    // divu with mflo waiting in ID: stall 0..9, released in DONE@10
    step(1, 2'b11, 0, 1, 0, 1, 0, 1);
    for (int i = 1; i <= 9; i++) step(0, 2'b00, 0, 1, 0, 0, 1, 1);
    step(0, 2'b00, 0, 1, 0, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0);

    // flushed mult: no go, no stall, no write
    step(1, 2'b00, 1, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 7; i++) step(0, 2'b00, 0, 0, 0, 0, 0, 0);

    // mult then div issued in mult's DONE cycle; a stray start while busy is ignored
    step(1, 2'b01, 0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) step(0, 2'b00, 0, 0, 0, 0, 1, 0);
    step(1, 2'b10, 0, 0, 0, 1, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0, 1, 0);
    step(1, 2'b00, 0, 0, 0, 0, 1, 0);
    for (int i = 8; i <= 14; i++) step(0, 2'b00, 0, 0, 0, 0, 1, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0);

    // div aborted by reset at t=4: idle@5, MDOp cleared, no write through t=15
    step(1, 2'b10, 0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 3; i++) step(0, 2'b00, 0, 0, 0, 0, 1, 0);
    reset = 1'b1;
    step(0, 2'b00, 0, 0, 0, 0, 1, 0);
    reset = 1'b0;
    for (int i = 5; i <= 15; i++) step(0, 2'b00, 0, 0, 0, 0, 0, 0);

    // divide by zero: fast retire when enabled, full latency otherwise
    step(1, 2'b10, 0, 0, 1, 1, 0, 0);
    for (int i = 1; i <= 9; i++) step(0, 2'b00, 0, 0, 0, 0, !FAST, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0);

    chk("sb_empty", (sb.size() == 0) ? 2'd1 : 2'd0, 2'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
